// File: rtl/exp_diff_mant_cmp_lza_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fphub_pkg
//  Purpose  : Shared defaults, typedefs and helpers for the FP-HUB operand
//             analysis stage (exp_diff_mant_cmp_lza).
//  Contents : M_DFLT/E_DFLT/LW_DFLT widths, exp_t/sexp_t/mant_t/sig_t/lzc_t,
//             sat_lzc() saturating count helper.
//  Revision : 1.0 - initial release
// ============================================================================
package fphub_pkg;

   localparam int M_DFLT  = 24;
   localparam int E_DFLT  = 8;
   localparam int LW_DFLT = $clog2(M_DFLT);

   typedef logic [E_DFLT-1:0]  exp_t;
   typedef logic [E_DFLT:0]    sexp_t;
   typedef logic [M_DFLT-1:0]  mant_t;
   typedef logic [M_DFLT:0]    sig_t;
   typedef logic [LW_DFLT-1:0] lzc_t;

   // Clamp a leading-zero count to the largest value an lw-bit field holds.
   function automatic int sat_lzc(input int cnt, input int lw);
      int max_v;
      max_v = (1 << lw) - 1;
      return (cnt > max_v) ? max_v : cnt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/exp_diff_mant_cmp_lza_if.sv
`default_nettype none
// ============================================================================
//  Module   : exp_diff_mant_cmp_lza_if
//  Purpose  : Operand/result bundle of the FP-HUB operand analysis stage.
//  Ports    : in_valid, Ex, Ey, Mx, My, A, B            (producer -> stage)
//             out_valid, dif, X_greater_than_Y, Ex_equal_Ey,
//             Mx_greater_than_My, shift_amt, lza_zero   (stage -> consumer)
//             diff_abs only when FPHUB_DIFF_ABS_EN is defined.
//  Modports : master (producer/consumer side), slave (the stage).
//  Revision : 1.0 - initial release
// ============================================================================
interface exp_diff_mant_cmp_lza_if
   import fphub_pkg::*;
#(
   parameter int M = M_DFLT,
   parameter int E = E_DFLT
);
   localparam int LW = $clog2(M);

   logic          in_valid;
   logic [E-1:0]  Ex;
   logic [E-1:0]  Ey;
   logic [M-1:0]  Mx;
   logic [M-1:0]  My;
   logic [M:0]    A;
   logic [M:0]    B;

   logic          out_valid;
   logic [E:0]    dif;
   logic          X_greater_than_Y;
   logic          Ex_equal_Ey;
   logic          Mx_greater_than_My;
   logic [LW-1:0] shift_amt;
   logic          lza_zero;
`ifdef FPHUB_DIFF_ABS_EN
   logic [E:0]    diff_abs;
`endif

`ifdef FPHUB_DIFF_ABS_EN
   modport master (
      output in_valid, Ex, Ey, Mx, My, A, B,
      input  out_valid, dif, X_greater_than_Y, Ex_equal_Ey,
             Mx_greater_than_My, shift_amt, lza_zero, diff_abs
   );
   modport slave (
      input  in_valid, Ex, Ey, Mx, My, A, B,
      output out_valid, dif, X_greater_than_Y, Ex_equal_Ey,
             Mx_greater_than_My, shift_amt, lza_zero, diff_abs
   );
`else
   modport master (
      output in_valid, Ex, Ey, Mx, My, A, B,
      input  out_valid, dif, X_greater_than_Y, Ex_equal_Ey,
             Mx_greater_than_My, shift_amt, lza_zero
   );
   modport slave (
      input  in_valid, Ex, Ey, Mx, My, A, B,
      output out_valid, dif, X_greater_than_Y, Ex_equal_Ey,
             Mx_greater_than_My, shift_amt, lza_zero
   );
`endif

endinterface
`default_nettype wire

// File: rtl/exp_diff_mant_cmp_lza_leading_zero_counter.sv
`default_nettype none
// ============================================================================
//  Module   : leading_zero_counter
//  Purpose  : Combinational leading-zero count of a W-bit word, saturated to
//             the LW-bit output range.
//  Ports    : d     in  W   word to scan (MSB first)
//             count out LW  leading zeros (W when d==0), saturated
//             zero  out 1   d == 0
//  Revision : 1.0 - initial release
// ============================================================================
module leading_zero_counter
   import fphub_pkg::*;
#(
   parameter int W  = 25,
   parameter int LW = 5
) (
   input  logic [W-1:0]  d,
   output logic [LW-1:0] count,
   output logic          zero
);

   int   w_cnt;
   logic w_found;

   // Scan from the MSB; the first set bit fixes the count.  An all-zero word
   // leaves the count at W.
   always_comb begin
      w_cnt   = W;
      w_found = 1'b0;
      for (int i = W - 1; i >= 0; i--) begin
         if (!w_found && d[i]) begin
            w_cnt   = W - 1 - i;
            w_found = 1'b1;
         end
      end
   end

   assign count = LW'(sat_lzc(w_cnt, LW));
   assign zero  = ~|d;

endmodule
`default_nettype wire

// File: rtl/exp_diff_mant_cmp_lza.sv
`default_nettype none
// ============================================================================
//  Module   : exp_diff_mant_cmp_lza
//  Purpose  : Registered operand-analysis stage of the FP-HUB adder: signed
//             exponent difference and order, mantissa compare, and exact
//             leading-zero count of |A-B|.  One-cycle latency, no stall.
//  Ports    : clk  - clock, rising edge
//             rst  - synchronous active-high reset (clears all outputs)
//             bus  - exp_diff_mant_cmp_lza_if.slave (operands and results)
//  Config   : FPHUB_DIFF_ABS_EN adds the registered diff_abs = |dif| output.
//  Revision : 1.0 - initial release
// ============================================================================
module exp_diff_mant_cmp_lza
   import fphub_pkg::*;
#(
   parameter int M = M_DFLT,
   parameter int E = E_DFLT
) (
   input  logic                    clk,
   input  logic                    rst,
   exp_diff_mant_cmp_lza_if.slave  bus
);

   localparam int LW = $clog2(M);

   logic [E:0]    w_dif;
   logic          w_x_gt;
   logic          w_e_eq;
   logic          w_m_gt;
   logic [M:0]    w_d;
   logic [LW-1:0] w_lz;
   logic          w_zero;

   logic          r_valid;
   logic [E:0]    r_dif;
   logic          r_x_gt;
   logic          r_e_eq;
   logic          r_m_gt;
   logic [LW-1:0] r_lz;
   logic          r_zero;

   // Zero-extending both exponents by one bit makes the difference exact in
   // E+1 bits two's complement.
   assign w_dif  = {1'b0, bus.Ex} - {1'b0, bus.Ey};
   assign w_x_gt = bus.Ex > bus.Ey;
   assign w_e_eq = bus.Ex == bus.Ey;
   assign w_m_gt = bus.Mx > bus.My;
   assign w_d    = (bus.A >= bus.B) ? (bus.A - bus.B) : (bus.B - bus.A);

   leading_zero_counter #(
      .W  (M + 1),
      .LW (LW)
   ) u_lzc (
      .d     (w_d),
      .count (w_lz),
      .zero  (w_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_dif   <= '0;
         r_x_gt  <= 1'b0;
         r_e_eq  <= 1'b0;
         r_m_gt  <= 1'b0;
         r_lz    <= '0;
         r_zero  <= 1'b0;
      end else begin
         r_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_dif  <= w_dif;
            r_x_gt <= w_x_gt;
            r_e_eq <= w_e_eq;
            r_m_gt <= w_m_gt;
            r_lz   <= w_lz;
            r_zero <= w_zero;
         end
      end
   end

   assign bus.out_valid          = r_valid;
   assign bus.dif                = r_dif;
   assign bus.X_greater_than_Y   = r_x_gt;
   assign bus.Ex_equal_Ey        = r_e_eq;
   assign bus.Mx_greater_than_My = r_m_gt;
   assign bus.shift_amt          = r_lz;
   assign bus.lza_zero           = r_zero;

`ifdef FPHUB_DIFF_ABS_EN
   logic [E:0] w_abs;
   logic [E:0] r_abs;

   // |dif| never exceeds 2^E-1, so negation cannot overflow E+1 bits.
   assign w_abs = w_dif[E] ? -w_dif : w_dif;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_abs <= '0;
      end else if (bus.in_valid) begin
         r_abs <= w_abs;
      end
   end

   assign bus.diff_abs = r_abs;
`endif

endmodule
`default_nettype wire

// File: tb/tb_exp_diff_mant_cmp_lza.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exp_diff_mant_cmp_lza
//  Purpose  : Self-checking bench for exp_diff_mant_cmp_lza (M=24, E=8) with a
//             behavioural reference model; FPHUB_DIFF_ABS_EN aware.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_exp_diff_mant_cmp_lza;
   import fphub_pkg::*;

`ifdef FPHUB_DIFF_ABS_EN
   localparam int VW = 28;
`else
   localparam int VW = 19;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   exp_diff_mant_cmp_lza_if #(.M(24), .E(8)) bus ();

   exp_diff_mant_cmp_lza #(.M(24), .E(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference state of the output registers.
   logic       e_valid;
   logic [8:0] e_dif;
   logic       e_xg, e_eq, e_mg, e_z;
   logic [4:0] e_sa;
   logic [8:0] e_abs;

   logic [VW-1:0] obs;
`ifdef FPHUB_DIFF_ABS_EN
   assign obs = {bus.out_valid, bus.dif, bus.X_greater_than_Y, bus.Ex_equal_Ey,
                 bus.Mx_greater_than_My, bus.shift_amt, bus.lza_zero, bus.diff_abs};
`else
   assign obs = {bus.out_valid, bus.dif, bus.X_greater_than_Y, bus.Ex_equal_Ey,
                 bus.Mx_greater_than_My, bus.shift_amt, bus.lza_zero};
`endif

   function automatic logic [VW-1:0] exp_vec();
`ifdef FPHUB_DIFF_ABS_EN
      return {e_valid, e_dif, e_xg, e_eq, e_mg, e_sa, e_z, e_abs};
`else
      return {e_valid, e_dif, e_xg, e_eq, e_mg, e_sa, e_z};
`endif
   endfunction

   task automatic model_step(input logic r, v, input exp_t ex, ey,
                             input mant_t mx, my, input sig_t a, b);
      int    dif;
      longint d;
      int    lz;
      if (r) begin
         e_valid = 0; e_dif = 0; e_xg = 0; e_eq = 0; e_mg = 0;
         e_sa = 0; e_z = 0; e_abs = 0;
      end else begin
         e_valid = v;
         if (v) begin
            dif   = int'(ex) - int'(ey);
            e_dif = 9'(dif);
            e_abs = 9'((dif < 0) ? -dif : dif);
            e_xg  = (int'(ex) > int'(ey));
            e_eq  = (ex == ey);
            e_mg  = (longint'(mx) > longint'(my));
            d     = (longint'(a) >= longint'(b)) ? longint'(a) - longint'(b)
                                                 : longint'(b) - longint'(a);
            lz    = 25 - $clog2(d + 1);        // bits needed for d, from 25
            if (lz > 31) lz = 31;
            e_sa  = 5'(lz);
            e_z   = (d == 0);
         end
      end
   endtask

   task automatic drive(input logic r, v, input exp_t ex, ey,
                        input mant_t mx, my, input sig_t a, b);
      @(negedge clk);
      rst = r; bus.in_valid = v;
      bus.Ex = ex; bus.Ey = ey; bus.Mx = mx; bus.My = my; bus.A = a; bus.B = b;
      @(posedge clk);
      model_step(r, v, ex, ey, mx, my, a, b);
      #1;
   endtask

   function automatic mant_t rmant();
      return mant_t'($urandom);
   endfunction

   function automatic sig_t rsig();
      return sig_t'($urandom);
   endfunction

   task automatic test_reset();
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 1, 8'h12, 8'h34, 1, 2, 3, 4);
      n_cmp++;
      if (obs !== exp_vec()) begin
         n_bad++;
         $display("FAIL reset: got %h expected %h", obs, exp_vec());
      end
   endtask

   task automatic test_exp_diff();
      drive(0, 1, 8'h85, 8'h80, rmant(), rmant(), rsig(), rsig());
      n_cmp++;
      if (obs !== exp_vec()) begin
         n_bad++;
         $display("FAIL exp_pos: got %h expected %h", obs, exp_vec());
      end
      n_cmp++;
      if (bus.dif !== 9'd5 || bus.X_greater_than_Y !== 1'b1 || bus.Ex_equal_Ey !== 1'b0) begin
         n_bad++;
         $display("FAIL exp_pos_const: got dif=%h gt=%b eq=%b expected 005 1 0",
                  bus.dif, bus.X_greater_than_Y, bus.Ex_equal_Ey);
      end
      drive(0, 1, 8'h10, 8'hF0, rmant(), rmant(), rsig(), rsig());
      n_cmp++;
      if (obs !== exp_vec()) begin
         n_bad++;
         $display("FAIL exp_neg: got %h expected %h", obs, exp_vec());
      end
      n_cmp++;
      if (bus.dif !== 9'h120 || bus.X_greater_than_Y !== 1'b0) begin
         n_bad++;
         $display("FAIL exp_neg_const: got dif=%h gt=%b expected 120 0",
                  bus.dif, bus.X_greater_than_Y);
      end
   endtask

   task automatic test_mant_cmp();
      mant_t mx [3] = '{24'h400000, 24'h3FFFFF, 24'h5A5A5A};
      mant_t my [3] = '{24'h3FFFFF, 24'h400000, 24'h5A5A5A};
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 8'h7F, 8'h7F, mx[i], my[i], rsig(), rsig());
         n_cmp++;
         if (obs !== exp_vec()) begin
            n_bad++;
            $display("FAIL mant_cmp[%0d]: got %h expected %h", i, obs, exp_vec());
         end
      end
   endtask

   task automatic test_lza();
      sig_t a [4] = '{25'h1000000, 25'h0FFFFFF, 25'h1800000, 25'h0ABCDEF};
      sig_t b [4] = '{25'h0FFFFFF, 25'h1000000, 25'h0800000, 25'h0ABCDEF};
      logic [4:0] want [4] = '{5'd24, 5'd24, 5'd0, 5'd25};
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, exp_t'($urandom), exp_t'($urandom), rmant(), rmant(), a[i], b[i]);
         n_cmp++;
         if (obs !== exp_vec() || bus.shift_amt !== want[i] || bus.lza_zero !== (i == 3)) begin
            n_bad++;
            $display("FAIL lza[%0d]: got %h sa=%0d expected %h sa=%0d",
                     i, obs, bus.shift_amt, exp_vec(), want[i]);
         end
      end
   endtask

   task automatic test_random();
      sig_t a, b;
      for (int i = 0; i < 300; i++) begin
         a = rsig();
         // Mostly near-equal significands so every count value is reached.
         b = (i % 3 == 0) ? rsig() : (a ^ sig_t'($urandom & ((1 << $urandom_range(0, 25)) - 1)));
         drive(0, logic'($urandom_range(0, 3) != 0), exp_t'($urandom),
               (i % 5 == 0) ? bus.Ex : exp_t'($urandom), rmant(), rmant(), a, b);
         n_cmp++;
         if (obs !== exp_vec()) begin
            n_bad++;
            $display("FAIL random[%0d]: got %h expected %h", i, obs, exp_vec());
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, exp_t'($urandom), exp_t'($urandom), rmant(), rmant(), rsig(), rsig());
         n_cmp++;
         if (obs !== exp_vec() || bus.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b[%0d]: got %h expected %h", i, obs, exp_vec());
         end
      end
      drive(1, 1, 8'h85, 8'h80, 24'h1, 24'h0, 25'h1, 25'h0);
      n_cmp++;
      if (obs !== exp_vec() || bus.out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_with_valid: got %h expected %h", obs, exp_vec());
      end
      drive(0, 1, 8'h33, 8'hC4, 24'h800000, 24'h1, 25'h0000100, 25'h0000001);
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, exp_t'($urandom), exp_t'($urandom), rmant(), rmant(), rsig(), rsig());
         n_cmp++;
         if (obs !== exp_vec() || bus.dif !== 9'(int'(8'h33) - int'(8'hC4))) begin
            n_bad++;
            $display("FAIL hold[%0d]: got %h expected %h", i, obs, exp_vec());
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.in_valid = 0; bus.Ex = 0; bus.Ey = 0; bus.Mx = 0; bus.My = 0;
      bus.A = 0; bus.B = 0;
      test_reset();
      test_exp_diff();
      test_mant_cmp();
      test_lza();
      test_random();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
